// File: rtl/axrm_pkg.sv
// rtl/axrm_pkg.sv - shared constants and types for the AxRM sequential divider
// Provides DW/VW defaults, the divider FSM state enum, the iteration count and
// the divide-by-zero quotient pattern.
// Build option: AXRM_DIV_TRUNC_EN reduces the iteration count to 14.
package axrm_pkg;

    localparam int DW_DEF = 16;
    localparam int VW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

`ifdef AXRM_DIV_TRUNC_EN
    // The two least-significant quotient iterations are skipped.
    localparam int ITER_CNT = DW_DEF - 2;
`else
    localparam int ITER_CNT = DW_DEF;
`endif

    localparam logic [15:0] DBZ_QUOT = 16'hFFFF;

endpackage

// File: rtl/axrm_div_step.sv
// rtl/axrm_div_step.sv - one combinational radix-2 restoring division step
// Ports:
//   r_in    [VW:0]   partial remainder before the step
//   bit_in           next dividend bit, shifted in at the LSB
//   divisor [VW-1:0] divisor
//   r_out   [VW:0]   partial remainder after the step
//   q_bit            quotient bit produced by the step
module axrm_div_step #(
    parameter int VW = 8
) (
    input  logic [VW:0]   r_in,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   r_out,
    output logic          q_bit
);

    logic [VW:0] r_shift;
    logic [VW:0] r_sub;
    // A restored remainder is always below the divisor, so its MSB is never
    // needed for the next shift.
    logic        unused_r_msb;

    assign unused_r_msb = r_in[VW];
    assign r_shift      = {r_in[VW-1:0], bit_in};
    assign r_sub        = r_shift - {1'b0, divisor};
    assign q_bit        = (r_shift >= {1'b0, divisor});
    assign r_out        = q_bit ? r_sub : r_shift;

endmodule

// File: rtl/axrm_div16by8_seq.sv
// rtl/axrm_div16by8_seq.sv - sequential restoring divider, one quotient bit per clock
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               operand handshake (dividend, divisor)
//   out_valid/out_ready             result handshake (quotient, remainder, div_by_zero)
// Build option: AXRM_DIV_TRUNC_EN runs 14 iterations and returns the quotient
// of (dividend>>2) shifted back left by 2.
module axrm_div16by8_seq
    import axrm_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW + 1);
    // Quotient bits skipped by the truncated build are re-inserted as zeros.
    localparam int QSHIFT = DW - ITER_CNT;

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [VW:0]   rem_q, rem_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] remd_q, remd_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   step_rem;
    logic          step_qbit;
    logic [DW-1:0] shreg_next;

    axrm_div_step #(.VW(VW)) u_step (
        .r_in    (rem_q),
        .bit_in  (shreg_q[DW-1]),
        .divisor (dvs_q),
        .r_out   (step_rem),
        .q_bit   (step_qbit)
    );

    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    assign shreg_next = {shreg_q[DW-2:0], step_qbit};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        quot_d    = quot_q;
        remd_d    = remd_q;
        dbz_d     = dbz_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (divisor == '0) begin
                        quot_d  = DW'(DBZ_QUOT);
                        remd_d  = dividend[VW-1:0];
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        shreg_d = dividend;
                        rem_d   = '0;
                        cnt_d   = '0;
                        dvs_d   = divisor;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                shreg_d = shreg_next;
                rem_d   = step_rem;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER_CNT - 1)) begin
                    quot_d  = shreg_next << QSHIFT;
                    remd_d  = step_rem[VW-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            remd_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = remd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_axrm_div16by8_seq.sv
// tb/tb_axrm_div16by8_seq.sv - directed self-checking bench for axrm_div16by8_seq
module tb_axrm_div16by8_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int checks = 0;
    int failures = 0;

`ifdef AXRM_DIV_TRUNC_EN
    localparam int LAT = 14;
`else
    localparam int LAT = 16;
`endif

    always #5 clk = ~clk;

    axrm_div16by8_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands for one edge, then counts edges until out_valid.
    task automatic start_div(input logic [15:0] dvd, input logic [7:0] dvs, output int lat);
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_div(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                           input logic [15:0] eq, input logic [7:0] er,
                           input logic edbz, input int elat);
        int lat;
        start_div(dvd, dvs, lat);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
        check({tag, "_rdy_busy"}, 32'(in_ready), 32'd0);
        finish_result(tag);
    endtask

    initial begin
        int lat;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        tick();

`ifdef AXRM_DIV_TRUNC_EN
        run_div("d1000_7", 16'd1000, 8'd7, 16'd140, 8'd5, 1'b0, LAT);
        run_div("d65025_255", 16'd65025, 8'd255, 16'd252, 8'd191, 1'b0, LAT);
        run_div("dffff_1", 16'hFFFF, 8'd1, 16'hFFFC, 8'd0, 1'b0, LAT);
`else
        run_div("d1000_7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, LAT);
        run_div("d65025_255", 16'd65025, 8'd255, 16'd255, 8'd0, 1'b0, LAT);
        run_div("dffff_1", 16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0, LAT);
`endif
        run_div("dbz", 16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1, 0);

        // Backpressure: result must hold and new operands must be ignored.
        start_div(16'd1000, 8'd7, lat);
        check("bp_lat", 32'(lat), 32'(LAT));
        dividend = 16'd500;
        divisor  = 8'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
`ifdef AXRM_DIV_TRUNC_EN
            check("bp_q", 32'(quotient), 32'd140);
            check("bp_r", 32'(remainder), 32'd5);
`else
            check("bp_q", 32'(quotient), 32'd142);
            check("bp_r", 32'(remainder), 32'd6);
`endif
            check("bp_ov", 32'(out_valid), 32'd1);
            check("bp_rdy", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        finish_result("bp");

        // Asynchronous reset in the middle of an iteration run.
        dividend = 16'd1000;
        divisor  = 8'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        check("mid_busy", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_rdy", 32'(in_ready), 32'd1);
        check("abort_ov", 32'(out_valid), 32'd0);
        check("abort_q", 32'(quotient), 32'd0);
        check("abort_r", 32'(remainder), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_no_ov", 32'(out_valid), 32'd0);
`ifdef AXRM_DIV_TRUNC_EN
        run_div("d200_9", 16'd200, 8'd9, 16'd20, 8'd5, 1'b0, LAT);
`else
        run_div("d200_9", 16'd200, 8'd9, 16'd22, 8'd2, 1'b0, LAT);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
